// File: rtl/noun_loader_pkg.sv
// Shared widths, memory function codes and loader state encodings for noun_loader.
`ifndef MEM_FUNC_WRITE
`define MEM_FUNC_WRITE 2'b01
`endif

package noun_loader_pkg;

    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTES_PER_WORD = (DATA_W + 7) / 8;
    localparam int unsigned ASM_W          = BYTES_PER_WORD * 8;
    localparam int unsigned IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned CNT_W          = 16;

    localparam logic [1:0] FUNC_NONE  = 2'b00;
    localparam logic [1:0] FUNC_WRITE = `MEM_FUNC_WRITE;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_HDR0 = 4'd1,
        ST_HDR1 = 4'd2,
        ST_BYTE = 4'd3,
        ST_REQ  = 4'd4,
        ST_WAIT = 4'd5,
        ST_DONE = 4'd6,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK  = 4'd7,
`endif
        ST_ERR  = 4'd8
    } state_t;

endpackage

// File: rtl/noun_loader_word_assembler.sv
// word_assembler: drops each incoming byte into its little-endian lane of the word being built.
module word_assembler
    import noun_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic [IDX_W-1:0] byte_idx,
    output logic [ASM_W-1:0] word_c,
    output logic             word_done_c
);

    logic [ASM_W-1:0] word_q;

    // Current word with this cycle's byte already merged, so the last byte needs no extra cycle.
    always_comb begin
        word_c = word_q;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (byte_valid && (byte_idx == IDX_W'(k))) begin
                word_c[k*8 +: 8] = byte_data;
            end
        end
    end

    assign word_done_c = byte_valid && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q <= '0;
        end else if (byte_valid) begin
            word_q <= word_c;
        end
    end

endmodule

// File: rtl/noun_loader.sv
// noun_loader: one-shot host-link frame loader that writes N little-endian words to memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
module noun_loader
    import noun_loader_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 1,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic [1:0]        mem_func,
    output logic              mem_execute,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] start_addr,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 2);

    state_t            state;
    logic [CNT_W-1:0]  n_words;
    logic [CNT_W-1:0]  word_cnt;
    logic [7:0]        n_lo;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [IDX_W-1:0]  byte_idx;
    logic              loaded;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk;
`endif

    logic              take_c;
    logic              timed_c;
    logic              tmo_expired_c;
    logic              asm_valid_c;
    logic [ASM_W-1:0]  asm_word_c;
    logic              asm_done_c;

    assign take_c      = in_valid && in_ready;
    assign asm_valid_c = take_c && (state == ST_BYTE);

    always_comb begin
        timed_c = (state == ST_HDR1) || (state == ST_BYTE);
`ifdef LOADER_CHECKSUM_EN
        timed_c = timed_c || (state == ST_CHK);
`endif
    end

    assign tmo_expired_c = timed_c && !in_valid && (tmo_cnt == TMO_W'(TIMEOUT));

    // Execute is qualified by mem_ready in the same cycle so the memory sees it while it is ready.
    assign mem_execute = (state == ST_REQ) && mem_ready;
    assign start_addr  = ADDR_W'(BASE_ADDR);

    word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (asm_valid_c),
        .byte_data   (in_data),
        .byte_idx    (byte_idx),
        .word_c      (asm_word_c),
        .word_done_c (asm_done_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            mem_func   <= FUNC_NONE;
            address    <= '0;
            write_data <= '0;
            word_cnt   <= '0;
            tmo_cnt    <= '0;
            n_words    <= '0;
            n_lo       <= '0;
            byte_idx   <= '0;
            loaded     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk        <= '0;
`endif
        end else begin
            load_done <= 1'b0;

            // Idle-gap counter only runs while the host owes us a byte mid-frame.
            if (timed_c && !in_valid) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

`ifdef LOADER_CHECKSUM_EN
            if (take_c && (state != ST_CHK)) begin
                chk <= chk ^ in_data;
            end
`endif

            if (tmo_expired_c) begin
                state      <= ST_ERR;
                in_ready   <= 1'b0;
                load_error <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!loaded) begin
                            state    <= ST_HDR0;
                            in_ready <= 1'b1;
                        end
                    end
                    ST_HDR0: begin
                        if (take_c) begin
                            n_lo  <= in_data;
                            state <= ST_HDR1;
                        end
                    end
                    ST_HDR1: begin
                        if (take_c) begin
                            n_words <= {in_data, n_lo};
                            if ({in_data, n_lo} == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                state    <= ST_CHK;
`else
                                state    <= ST_DONE;
                                in_ready <= 1'b0;
`endif
                            end else begin
                                state <= ST_BYTE;
                            end
                        end
                    end
                    ST_BYTE: begin
                        if (asm_valid_c) begin
                            byte_idx <= asm_done_c ? '0 : byte_idx + IDX_W'(1);
                        end
                        if (asm_done_c) begin
                            state      <= ST_REQ;
                            in_ready   <= 1'b0;
                            address    <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt);
                            mem_func   <= FUNC_WRITE;
                            write_data <= asm_word_c[DATA_W-1:0];
                        end
                    end
                    ST_REQ: begin
                        if (mem_ready) begin
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_ready) begin
                            word_cnt <= word_cnt + CNT_W'(1);
                            mem_func <= FUNC_NONE;
                            if (word_cnt + CNT_W'(1) == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                                state    <= ST_CHK;
                                in_ready <= 1'b1;
`else
                                state    <= ST_DONE;
`endif
                            end else begin
                                state    <= ST_BYTE;
                                in_ready <= 1'b1;
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (take_c) begin
                            in_ready <= 1'b0;
                            if (in_data == chk) begin
                                state <= ST_DONE;
                            end else begin
                                state      <= ST_ERR;
                                load_error <= 1'b1;
                            end
                        end
                    end
`endif
                    ST_DONE: begin
                        state     <= ST_IDLE;
                        load_done <= 1'b1;
                        loaded    <= 1'b1;
                    end
                    ST_ERR: begin
                        in_ready   <= 1'b0;
                        load_error <= 1'b1;
                    end
                    default: begin
                        state      <= ST_ERR;
                        in_ready   <= 1'b0;
                        load_error <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noun_loader.sv
// Directed self-checking bench for noun_loader: frame table plus stall, timeout, reset and checksum sequences.
module tb_noun_loader;
    import noun_loader_pkg::*;

    localparam int unsigned BASE = 1;
    localparam int unsigned TMO  = 60;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = 8'h00;
    logic [1:0]        mem_func;
    logic              mem_execute;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              mem_ready = 1'b1;
    logic [ADDR_W-1:0] start_addr;
    logic              load_done;
    logic              load_error;

    noun_loader #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mem_func    (mem_func),
        .mem_execute (mem_execute),
        .address     (address),
        .write_data  (write_data),
        .mem_ready   (mem_ready),
        .start_addr  (start_addr),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    nb;
        logic [0:15][7:0]      b;
        int                    nw;
        logic [0:2][15:0]      a;
        logic [0:2][31:0]      d;
        int                    lat;
    } vec_t;

    vec_t vt[4];

    logic [ADDR_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];
    logic [1:0]        wr_func[$];
    int                done_cnt = 0;
    int                total = 0;
    int                bad = 0;
    logic [7:0]        tx[$];

    // Memory-side observer: every execute pulse and every load_done cycle.
    always @(negedge clk) begin
        if (mem_execute === 1'b1) begin
            wr_addr.push_back(address);
            wr_data.push_back(write_data);
            wr_func.push_back(mem_func);
        end
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    64'(in_ready),    64'd0);
        check({tag, "_mem_execute"}, 64'(mem_execute), 64'd0);
        check({tag, "_load_done"},   64'(load_done),   64'd0);
        check({tag, "_load_error"},  64'(load_error),  64'd0);
        check({tag, "_mem_func"},    64'(mem_func),    64'd0);
        check({tag, "_address"},     64'(address),     64'd0);
        check({tag, "_write_data"},  64'(write_data),  64'd0);
        check({tag, "_start_addr"},  64'(start_addr),  64'(BASE));
    endtask

    task automatic reset_dut(input string tag);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; mem_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check({tag, "_ready_after_reset"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_tx();
        for (int i = 0; i < tx.size(); i++) begin
            int w;
            w = 0;
            in_valid = 1'b1;
            in_data  = tx[i];
            @(negedge clk);
            while (in_ready !== 1'b1 && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (in_ready !== 1'b1) begin
                check("in_ready_wait", 64'(in_ready), 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (load_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 64'(got), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   wb, db;
        bit   rdy_seen;
        logic [7:0] x;

        vt[0].nb = 10;
        vt[0].b  = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'ha5, 8'h5a,
                    8'h0f, 8'hf0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[0].nw = 2;
        vt[0].a  = {16'd1, 16'd2, 16'd0};
        vt[0].d  = {32'h44332211, 32'hf00f5aa5, 32'h0};
        vt[0].lat = 20;

        vt[1].nb = 2;
        vt[1].b  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[1].nw = 0;
        vt[1].a  = {16'd0, 16'd0, 16'd0};
        vt[1].d  = {32'h0, 32'h0, 32'h0};
        vt[1].lat = 2;

        vt[2].nb = 6;
        vt[2].b  = {8'h01, 8'h00, 8'hde, 8'had, 8'hbe, 8'hef, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[2].nw = 1;
        vt[2].a  = {16'd1, 16'd0, 16'd0};
        vt[2].d  = {32'hefbeadde, 32'h0, 32'h0};
        vt[2].lat = 20;

        vt[3].nb = 14;
        vt[3].b  = {8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hff, 8'hff,
                    8'hff, 8'hff, 8'h80, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        vt[3].nw = 3;
        vt[3].a  = {16'd1, 16'd2, 16'd3};
        vt[3].d  = {32'h04030201, 32'hffffffff, 32'h01000080};
        vt[3].lat = 20;

        // Table-driven frames, each after a fresh reset.
        for (int v = 0; v < 4; v++) begin
            reset_dut($sformatf("v%0d_rst", v));
            wb = wr_addr.size();
            db = done_cnt;
            tx.delete();
            x = 8'h00;
            for (int i = 0; i < vt[v].nb; i++) begin
                tx.push_back(vt[v].b[i]);
                x = x ^ vt[v].b[i];
            end
`ifdef LOADER_CHECKSUM_EN
            tx.push_back(x);
`endif
            send_tx();
            wait_done($sformatf("v%0d_done_latency", v), vt[v].lat);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulses", v), 64'(done_cnt - db), 64'd1);
            check($sformatf("v%0d_write_count", v), 64'(wr_addr.size() - wb), 64'(vt[v].nw));
            for (int i = 0; i < vt[v].nw; i++) begin
                if (wb + i < wr_addr.size()) begin
                    check($sformatf("v%0d_w%0d_addr", v, i), 64'(wr_addr[wb + i]), 64'(vt[v].a[i]));
                    check($sformatf("v%0d_w%0d_data", v, i), 64'(wr_data[wb + i]), 64'(vt[v].d[i]));
                    check($sformatf("v%0d_w%0d_func", v, i), 64'(wr_func[wb + i]), 64'd1);
                end
            end
            check($sformatf("v%0d_load_error", v), 64'(load_error), 64'd0);
            check($sformatf("v%0d_idle_ready", v), 64'(in_ready), 64'd0);
        end

        // One-shot: a second frame after completion is ignored.
        wb = wr_addr.size();
        db = done_cnt;
        rdy_seen = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h01;
        repeat (10) begin
            @(negedge clk);
            if (in_ready === 1'b1) rdy_seen = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("oneshot_ready", 64'(rdy_seen), 64'd0);
        check("oneshot_writes", 64'(wr_addr.size() - wb), 64'd0);
        check("oneshot_done", 64'(done_cnt - db), 64'd0);

        // Memory not ready for 5 cycles while a request is pending.
        reset_dut("stall_rst");
        wb = wr_addr.size();
        db = done_cnt;
        mem_ready = 1'b0;
        tx = {8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        send_tx();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_exec", k), 64'(mem_execute), 64'd0);
            check($sformatf("stall%0d_addr", k), 64'(address), 64'd1);
            check($sformatf("stall%0d_data", k), 64'(write_data), 64'h78563412);
            check($sformatf("stall%0d_func", k), 64'(mem_func), 64'd1);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("stall_release_exec", 64'(mem_execute), 64'd1);
        check("stall_release_addr", 64'(address), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_wait_exec", 64'(mem_execute), 64'd0);
        check("stall_wait_addr", 64'(address), 64'd1);
        check("stall_wait_data", 64'(write_data), 64'h78563412);
        check("stall_wait_func", 64'(mem_func), 64'd1);
        @(posedge clk); #1;
`ifdef LOADER_CHECKSUM_EN
        tx = {8'h01 ^ 8'h00 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78};
        send_tx();
`endif
        wait_done("stall_done_latency", 20);
        repeat (2) @(posedge clk);
        #1;
        check("stall_write_count", 64'(wr_addr.size() - wb), 64'd1);
        check("stall_done_pulses", 64'(done_cnt - db), 64'd1);

        // Host goes quiet mid-word: error exactly after TIMEOUT+1 idle cycles.
        reset_dut("tmo_rst");
        wb = wr_addr.size();
        db = done_cnt;
        tx = {8'h02, 8'h00, 8'haa, 8'hbb};
        send_tx();
        repeat (TMO) @(posedge clk);
        @(negedge clk);
        check("tmo_edge_error", 64'(load_error), 64'd0);
        check("tmo_edge_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("tmo_error", 64'(load_error), 64'd1);
        check("tmo_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'hcc;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("tmo_sticky_error", 64'(load_error), 64'd1);
        check("tmo_sticky_ready", 64'(in_ready), 64'd0);
        check("tmo_writes", 64'(wr_addr.size() - wb), 64'd0);
        check("tmo_done", 64'(done_cnt - db), 64'd0);

        // Reset asserted partway through word 1 of a 3-word frame.
        reset_dut("mid_rst0");
        wb = wr_addr.size();
        db = done_cnt;
        tx = {8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_tx();
        check("mid_pre_writes", 64'(wr_addr.size() - wb), 64'd1);
        if (wr_addr.size() > wb) begin
            check("mid_pre_data", 64'(wr_data[wb]), 64'h04030201);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
        wb = wr_addr.size();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("mid_post_writes", 64'(wr_addr.size() - wb), 64'd0);
        check("mid_post_done", 64'(done_cnt - db), 64'd0);
        check("mid_post_ready", 64'(in_ready), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte: error, no completion.
        reset_dut("chk_rst");
        wb = wr_addr.size();
        db = done_cnt;
        tx = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_tx();
        repeat (5) @(posedge clk);
        #1;
        check("chk_bad_error", 64'(load_error), 64'd1);
        check("chk_bad_ready", 64'(in_ready), 64'd0);
        check("chk_bad_done", 64'(done_cnt - db), 64'd0);
        check("chk_bad_writes", 64'(wr_addr.size() - wb), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noun_loader.md
NOUN_LOADER -- requirements
Module: noun_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 1, which is the first memory address written and the value driven on start_addr.
REQ-002 SHALL have parameter TIMEOUT, default 1023, which is the maximum number of idle cycles between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 8): the byte-stream handshake from the host link.
REQ-006 SHALL have ports mem_func (output, 2), mem_execute (output, 1), address (output, `memory_addr_width), write_data (output, `memory_data_width) and mem_ready (input, 1): the memory request port, muxed ahead of the traversal unit.
REQ-007 SHALL have ports start_addr (output, `memory_addr_width), load_done (output, 1) and load_error (output, 1) for traversal kick-off and status.

Function
REQ-008 SHALL accept a frame as follows: 2-byte little-endian word count N, then N words of W = ceil(`memory_data_width/8) bytes each, little-endian; bits above `memory_data_width are discarded.
REQ-009 SHALL transfer a byte only in a cycle where in_valid and in_ready are both 1.
REQ-010 SHALL drive in_ready = 1 only in states HDR0, HDR1, BYTE and CHK.
REQ-011 SHALL implement the states IDLE -> HDR0 -> HDR1 -> BYTE -> REQ -> WAIT -> (BYTE | CHK | DONE), plus ERR.
REQ-012 SHALL leave IDLE for HDR0 on the first cycle after reset is released.
REQ-013 SHALL go from HDR1 directly to DONE (or CHK) with no memory writes when N == 0.
REQ-014 SHALL enter REQ when word i (0-based) is complete, and in REQ drive address = BASE_ADDR + i (modulo 2^`memory_addr_width), mem_func = `MEM_FUNC_WRITE and write_data = the assembled word.
REQ-015 SHALL pulse mem_execute for exactly one cycle, in the first REQ cycle where mem_ready == 1, and then move to WAIT.
REQ-016 SHALL hold address, mem_func and write_data stable from REQ until WAIT exits.
REQ-017 SHALL stay in WAIT for at least 1 cycle and exit on the first cycle with mem_ready == 1 after that.
REQ-018 SHALL not enter REQ again before WAIT exits, so at most one memory request is outstanding.
REQ-019 SHALL go from DONE to IDLE and assert load_done as a 1-cycle pulse on that transition.
REQ-020 SHALL drive start_addr = BASE_ADDR constantly.
REQ-021 SHALL go to ERR, set load_error = 1 (sticky until reset) and drop in_ready, when more than TIMEOUT consecutive cycles pass with in_valid == 0 while in HDR1, BYTE or CHK.
REQ-022 SHALL never leave ERR except through reset.
REQ-023 SHALL leave a new frame in IDLE after DONE until the next reset, because load is one-shot per reset.

Reset
REQ-024 SHALL, while rst == 0 at a clock edge, set the state to IDLE and set in_ready, mem_execute, load_done and load_error to 0, mem_func to 2'b00, and address, write_data, the word counter and the timeout counter to 0.
REQ-025 SHALL abandon a frame that is reset mid-operation, with no further mem_execute after reset.

Configuration
REQ-026 SHALL, when LOADER_CHECKSUM_EN is defined, expect a final CHK byte equal to the XOR of all preceding frame bytes; on a match it goes to DONE, on a mismatch it goes to ERR with load_done never pulsed.
REQ-027 SHALL, when LOADER_CHECKSUM_EN is undefined, have no CHK state, and WAIT after the last word (or HDR1 with N == 0) goes straight to DONE.

Structure
REQ-028 SHALL use `memory_addr_width, `memory_data_width and `MEM_FUNC_WRITE (2'b01) from the shared memory_unit.vh header, and state encodings from a shared loader_defs.vh.
REQ-029 SHALL place byte-to-word assembly in a sub-module named word_assembler (byte in, byte index, word-complete flag).

Verification
REQ-030 SHALL verify: N=2 frame with bytes streamed back-to-back and mem_ready = 1 -> writes to addresses 1 and 2 with the correct little-endian data, then one load_done pulse.
REQ-031 SHALL verify: N=0 frame -> zero mem_execute pulses and load_done asserted within 2 cycles of the second header byte.
REQ-032 SHALL verify: mem_ready held low for 5 cycles during a request -> mem_execute fires on the first cycle with mem_ready = 1, and address and write_data stay stable throughout.
REQ-033 SHALL verify: in_valid stalled for TIMEOUT+1 cycles mid-word -> load_error = 1, in_ready = 0, and no further writes.
REQ-034 SHALL verify: rst driven low during word 1 of N=3 -> all outputs return to their reset values and no mem_execute occurs after reset.
REQ-035 SHALL verify, with LOADER_CHECKSUM_EN defined: a frame with a wrong checksum byte -> load_error = 1 and no load_done; the correct checksum -> load_done.
